// File: rtl/ram_dma_pkg.sv
// Shared types for the RAM block-copy / block-fill engine.
package ram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma.sv
// RAM port initiator: CPU pass-through when idle, block copy/fill engine when started.
//
// state | meaning
// IDLE  | CPU owns the RAM port (pass-through), waiting for start
// READ  | copy only: fetch word at sp into rbuf
// WRITE | store rbuf (copy) or pattern (fill) at dp, count down
// DONE  | one-cycle completion pulse, CPU already back on the port
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              CPUclk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [WIDTH-1:0]  pattern,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    input  logic              cpu_we,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_we,
    input  logic [WIDTH-1:0]  ram_rdata
);

    dma_state_t        state;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] dp;
    logic [ADDR_W:0]   cnt;
    logic [WIDTH-1:0]  rbuf;
    logic              mode_q;
    logic [WIDTH-1:0]  pattern_q;

    always_ff @(posedge CPUclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sp        <= '0;
            dp        <= '0;
            cnt       <= '0;
            rbuf      <= '0;
            mode_q    <= MODE_COPY;
            pattern_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        pattern_q <= pattern;
                        sp        <= src;
                        dp        <= dst;
                        cnt       <= len;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (mode == MODE_FILL) begin
                            state <= WRITE;
                            busy  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rbuf  <= ram_rdata;
                        sp    <= sp + ADDR_W'(1);
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    // The write presented this cycle commits even when aborting.
                    dp  <= dp + ADDR_W'(1);
                    cnt <= cnt - (ADDR_W+1)'(1);
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == (ADDR_W+1)'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (mode_q == MODE_FILL) begin
                        state <= WRITE;
                    end else begin
                        state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux; reset gates the write enable so no stray write can slip through.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        case (state)
            READ: begin
                ram_addr = sp;
                ram_we   = 1'b0;
            end
            WRITE: begin
                ram_addr  = dp;
                ram_wdata = (mode_q == MODE_FILL) ? pattern_q : rbuf;
                ram_we    = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    assign cpu_rdata = ram_rdata;
    assign cpu_stall = busy;

endmodule

// File: tb/tb_ram_dma.sv
// Randomized bench for ram_dma with a behavioural RAM and an array-based reference model.
module tb_ram_dma;
    import ram_dma_pkg::*;

    logic        CPUclk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [15:0] pattern;
    logic        abort;
    logic        busy;
    logic        done;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CPUclk = ~CPUclk;

    ram_dma #(.WIDTH(16), .ADDR_W(8)) dut (
        .CPUclk    (CPUclk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .pattern   (pattern),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    // RAM: combinational read, synchronous write
    assign ram_rdata = mem[ram_addr];
    always @(posedge CPUclk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) d++;
        end
        return d;
    endfunction

    task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            ref_mem[8'(d + 8'(i))] = ref_mem[8'(s + 8'(i))];
        end
    endtask

    task automatic ref_fill(input logic [7:0] d, input int n, input logic [15:0] p);
        for (int i = 0; i < n; i++) begin
            ref_mem[8'(d + 8'(i))] = p;
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] v);
        @(negedge CPUclk);
        cpu_addr  = a;
        cpu_wdata = v;
        cpu_we    = 1'b1;
        @(negedge CPUclk);
        cpu_we    = 1'b0;
        ref_mem[a] = v;
    endtask

    // Runs one operation and checks timing, address sequence and resulting memory.
    task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d, input int n,
                          input logic [15:0] p, input bit cpu_hold, input bit restart);
        int exp_busy, busy_cyc, done_at, we_cnt, addr_err, stall_err;
        logic [7:0] ea;
        logic       ewe;
        exp_busy = (m == MODE_FILL) ? n : 2 * n;
        @(negedge CPUclk);
        mode = m; src = s; dst = d; len = 9'(n); pattern = p; start = 1'b1;
        @(negedge CPUclk);
        start = 1'b0;
        if (cpu_hold) begin
            cpu_addr = 8'h20; cpu_wdata = 16'h5555; cpu_we = 1'b1;
        end
        busy_cyc = 0; done_at = -1; we_cnt = 0; addr_err = 0; stall_err = 0;
        for (int c = 0; c < exp_busy + 8 && done_at < 0; c++) begin
            start = 1'b0;
            if (cpu_stall !== busy) stall_err++;
            if (busy) begin
                if (m == MODE_FILL) begin
                    ea  = d + 8'(busy_cyc);
                    ewe = 1'b1;
                end else begin
                    ea  = (busy_cyc % 2 == 0) ? s + 8'(busy_cyc / 2) : d + 8'(busy_cyc / 2);
                    ewe = (busy_cyc % 2) == 1;
                end
                if (ram_addr !== ea || ram_we !== ewe) addr_err++;
                if (ram_we) we_cnt++;
                if (restart && busy_cyc == 2) begin
                    mode = MODE_COPY; src = 8'h00; dst = 8'h30; len = 9'd5; start = 1'b1;
                end
                busy_cyc++;
            end
            if (done === 1'b1) begin
                done_at = c;
                cpu_we  = 1'b0;
            end else begin
                @(negedge CPUclk);
            end
        end
        start  = 1'b0;
        cpu_we = 1'b0;
        chk("busy_cycles", busy_cyc, exp_busy);
        chk("done_at", done_at, exp_busy);
        chk("write_count", we_cnt, n);
        chk("addr_seq", addr_err, 0);
        chk("stall_eq_busy", stall_err, 0);
        @(negedge CPUclk);
        chk("idle_after_done", {busy, done}, 2'b00);
        if (m == MODE_FILL) ref_fill(d, n, p);
        else ref_copy(s, d, n);
        chk("mem_after_op", mem_diff(), 0);
    endtask

    initial begin
        int wr;
        logic dn;
        logic [7:0] a;
        logic [15:0] p;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        pattern = '0; abort = 1'b0; cpu_addr = 8'h05; cpu_wdata = 16'hDEAD; cpu_we = 1'b1;
        #1;
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_busy_done", {busy, done, cpu_stall}, 3'b000);
        repeat (2) @(negedge CPUclk);
        cpu_we = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 256; i++) cpu_write(8'(i), 16'($urandom));
        chk("preload", mem_diff(), 0);
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            cpu_addr = a;
            #1;
            chk("cpu_rdata", cpu_rdata, ref_mem[a]);
        end

        // directed scenarios
        run_op(MODE_FILL, 8'h00, 8'h10, 4, 16'hABCD, 1'b0, 1'b0);
        chk("fill_word", mem[8'h12], 16'hABCD);
        cpu_write(8'h00, 16'd1); cpu_write(8'h01, 16'd2); cpu_write(8'h02, 16'd3);
        run_op(MODE_COPY, 8'h00, 8'h80, 3, 16'h0000, 1'b0, 1'b0);
        chk("copy_word", mem[8'h82], 16'd3);
        run_op(MODE_FILL, 8'h00, 8'hFE, 4, 16'h7E57, 1'b0, 1'b0);
        chk("wrap_word", mem[8'h01], 16'h7E57);
        run_op(MODE_COPY, 8'h10, 8'h50, 0, 16'h0000, 1'b0, 1'b0);
        run_op(MODE_FILL, 8'h00, 8'h20, 8, 16'h1111, 1'b1, 1'b0);
        chk("cpu_we_dropped", mem[8'h20], 16'h1111);
        cpu_write(8'h20, 16'h5555);
        chk("cpu_we_after", mem[8'h20], 16'h5555);
        run_op(MODE_COPY, 8'h40, 8'h42, 6, 16'h0000, 1'b0, 1'b0);
        run_op(MODE_FILL, 8'h00, 8'h90, 10, 16'h2468, 1'b0, 1'b1);

        // abort during the third WRITE of a copy
        @(negedge CPUclk);
        mode = MODE_COPY; src = 8'h40; dst = 8'hC0; len = 9'd8; start = 1'b1;
        @(negedge CPUclk);
        start = 1'b0;
        wr = 0;
        for (int c = 0; c < 40 && wr < 3; c++) begin
            if (busy && ram_we) wr++;
            if (wr < 3) @(negedge CPUclk);
        end
        chk("abort_reach", wr, 3);
        abort = 1'b1;
        @(negedge CPUclk);
        abort = 1'b0;
        chk("abort_idle", {busy, done}, 2'b00);
        dn = 1'b0;
        repeat (5) begin
            @(negedge CPUclk);
            dn = dn | done | busy;
        end
        chk("abort_no_done", dn, 1'b0);
        ref_copy(8'h40, 8'hC0, 3);
        chk("abort_mem", mem_diff(), 0);

        // reset in the middle of a fill
        @(negedge CPUclk);
        mode = MODE_FILL; dst = 8'h60; len = 9'd20; pattern = 16'hC0DE; start = 1'b1;
        @(negedge CPUclk);
        start = 1'b0;
        wr = 0;
        for (int c = 0; c < 40 && wr < 5; c++) begin
            if (busy && ram_we) wr++;
            if (wr < 5) @(negedge CPUclk);
        end
        chk("rst_reach", wr, 5);
        rst = 1'b1;
        #1;
        chk("midrst_we", ram_we, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(negedge CPUclk);
        chk("midrst_done", done, 1'b0);
        rst = 1'b0;
        ref_fill(8'h60, 4, 16'hC0DE);
        chk("midrst_mem", mem_diff(), 0);

        // random operations against the reference model
        for (int k = 0; k < 10; k++) begin
            p = 16'($urandom);
            run_op(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 48)), p, 1'b0, 1'b0);
        end
        run_op(MODE_COPY, 8'($urandom), 8'($urandom), 256, 16'h0000, 1'b0, 1'b0);
        run_op(MODE_FILL, 8'h00, 8'($urandom), 256, 16'($urandom), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
- Single-port initiator for the 16-bit × 256-word RAM. It sits between the CPU data port and the RAM and drives `addr`/`wdata`/`we` on the RAM side.
- When idle, CPU accesses pass straight through to the RAM.
- On `start` it takes ownership of the RAM port and runs one of two operations:
  - block copy from `src` to `dst`;
  - block fill of `dst` with a constant pattern.
- CPU accesses are stalled while the engine owns the port.

Parameters:
- WIDTH, 16, data word width; must match the RAM `WIDTH`.
- ADDR_W, 8, RAM address width; the address space is 2^ADDR_W words.

Ports:
- CPUclk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; latched at start.
- src  in  ADDR_W  copy source base address; latched at start.
- dst  in  ADDR_W  destination base address; latched at start.
- len  in  ADDR_W+1  word count, 0..256; latched at start.
- pattern  in  WIDTH  fill value; latched at start.
- abort  in  1  terminates the current operation.
- busy  out  1  engine owns the RAM port.
- done  out  1  one-cycle pulse on normal completion.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_rdata  out  WIDTH  read data returned to the CPU.
- cpu_stall  out  1  CPU access not serviced this cycle; equals `busy`.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  WIDTH  RAM read data; combinational from `ram_addr`, same cycle.

Behaviour:
- States: IDLE, READ, WRITE, DONE. Registers:
  - `sp`, `dp`: ADDR_W-bit source and destination pointers;
  - `cnt`: ADDR_W+1-bit remaining-word count;
  - `buf`: WIDTH-bit read holding register;
  - latched `mode` and `pattern`.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; `busy` = 0, `done` = 0, `ram_we` = 0;
  - `sp`, `dp`, `cnt`, `buf` = 0.
- IDLE:
  - RAM port is in pass-through: `ram_addr` = `cpu_addr`, `ram_wdata` = `cpu_wdata`, `ram_we` = `cpu_we`.
  - If `start` is 1 at an edge, latch all operands and set `sp` = `src`, `dp` = `dst`, `cnt` = `len`. Next state:
    - `len` = 0 → DONE;
    - `mode` = 1 → WRITE;
    - otherwise → READ.
- READ (copy mode only):
  - `ram_addr` = `sp`, `ram_we` = 0.
  - At the edge: `buf` <= `ram_rdata`, `sp` <= `sp` + 1, next state WRITE.
- WRITE:
  - `ram_addr` = `dp`, `ram_we` = 1.
  - `ram_wdata` = `buf` in copy mode, `pattern` in fill mode.
  - At the edge: `dp` <= `dp` + 1, `cnt` <= `cnt` − 1. Next state:
    - `cnt` = 1 → DONE;
    - otherwise → READ (copy) or WRITE (fill).
- DONE:
  - `done` = 1 for exactly this one cycle; `busy` = 0.
  - RAM port is already in pass-through.
  - Next state is unconditionally IDLE.
  - `start` is ignored in DONE.
- `busy` = 1 exactly in READ and WRITE. `cpu_stall` = `busy`.
- While `busy` = 1, `cpu_we` is dropped: it never reaches the RAM and is not queued.
- `cpu_rdata` = `ram_rdata` at all times. The CPU must ignore it while `cpu_stall` = 1.
- Throughput:
  - copy takes 2 cycles per word; `len` = N gives 2N busy cycles;
  - fill takes 1 cycle per word; N busy cycles;
  - `done` follows in the cycle after the last write.
- Pointer arithmetic is modulo 2^ADDR_W: 0xFF + 1 = 0x00, with no error flag.
- `len` = 256 covers the whole memory.
- Overlapping copy runs in ascending order, one word at a time, so `dst` > `src` with overlap replicates data. This is the defined behaviour, not an error.
- `abort`:
  - When `abort` = 1 at an edge in READ or WRITE, next state is IDLE and `done` is not pulsed.
  - A write already presented in that WRITE cycle commits at that edge.
  - `abort` has no effect in IDLE or DONE.
- `start` while `busy` = 1 is ignored; it is not queued.
- Reset mid-operation: `ram_we` drops combinationally, no further writes occur, and RAM contents are left as written so far.

Decomposition:
- Shared package `ram_dma_pkg`:
  - state enum `dma_state_t` {IDLE, READ, WRITE, DONE};
  - mode constants `MODE_COPY` = 0, `MODE_FILL` = 1.
- No sub-module: the FSM, datapath and port mux live in one module.
- The bench instantiates `ram_dma` together with the existing RAM.

Test Plan:
- Fill: `mode`=1, `dst`=0x10, `len`=4, `pattern`=0xABCD → `ram_we`=1 for 4 consecutive cycles at addresses 0x10..0x13; `busy` high for 4 cycles; then `done` for 1 cycle; mem[0x10..0x13] = 0xABCD.
- Copy: mem[0..2] preloaded with 1, 2, 3; `mode`=0, `src`=0x00, `dst`=0x80, `len`=3 → `busy` high for 6 cycles with READ/WRITE alternating; `done` pulses; mem[0x80..0x82] = 1, 2, 3; source unchanged.
- Wrap and zero length:
  - fill `dst`=0xFE, `len`=4 → writes at 0xFE, 0xFF, 0x00, 0x01;
  - `len`=0 → `busy` never asserts, `done` in the cycle after `start`, no `ram_we`.
- CPU arbitration:
  - `cpu_we`=1 to 0x20 with value 0x5555 during a fill of 0x20..0x27 with 0x1111 → `cpu_stall`=1 throughout and mem[0x20] = 0x1111;
  - the same CPU write after `done` → mem[0x20] = 0x5555.
- Abort: copy `len`=8, `abort` asserted in the 3rd WRITE cycle → exactly 3 destination words written, no `done`, back to IDLE, `busy`=0 next cycle.
- Reset and ignored start:
  - `rst` asserted mid-fill → `ram_we`=0 immediately, state IDLE, `done` not pulsed;
  - a second `start` pulse while `busy`=1 → ignored; only the first operation's words are written.
